// File: rtl/test_sequencer.sv
// Fixture sequencer: arms each test in turn, watches for a pass, a fail or a
// watchdog timeout, and reports the outcome on the RGB LED.
module test_sequencer #(
    parameter int N_TESTS      = 4,
    parameter int DELAY_BITS   = 6,
    parameter int TIMEOUT_BITS = 16,
    parameter int BLINK_BITS   = 22
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic [N_TESTS-1:0] o_run,
    input  logic [N_TESTS-1:0] i_running,
    input  logic [N_TESTS-1:0] i_passed,
    output logic               o_led_r,
    output logic               o_led_g,
    output logic               o_led_b,
    output logic               o_done,
    output logic [2:0]         o_fail_idx,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        DELAY, ARM, RUN, NEXT, PASS, FAIL
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(N_TESTS - 1);
    localparam logic [TIMEOUT_BITS-1:0] WD_LAST =
        {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    logic [1:0]              rst_sync;
    logic                    rst_n;
    state_t                  state, state_nx;
    logic [2:0]              idx, idx_nx;
    logic [2:0]              fail_idx, fail_idx_nx;
    logic                    timeout, timeout_nx;
    logic [DELAY_BITS-1:0]   dly;
    logic [TIMEOUT_BITS-1:0] wd;
    logic [BLINK_BITS-1:0]   blink;
    logic [3:0]              pulse;
    logic [7:0]              running_w, passed_w;
    logic                    cur_running, cur_passed;
    logic                    wd_hit, active, blink_on;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    assign running_w   = 8'(i_running);
    assign passed_w    = 8'(i_passed);
    assign cur_running = running_w[idx];
    assign cur_passed  = passed_w[idx];
    // This cycle's increment makes the watchdog all-ones.
    assign wd_hit      = (wd == WD_LAST);

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        fail_idx_nx = fail_idx;
        timeout_nx  = timeout;
        unique case (state)
            DELAY: begin
                if (&dly) begin
                    state_nx = ARM;
                    idx_nx   = 3'd0;
                end
            end
            ARM: begin
                if (wd_hit) begin
                    state_nx    = FAIL;
                    fail_idx_nx = idx;
                    timeout_nx  = 1'b1;
                end else if (cur_running) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!cur_running) begin
                    if (cur_passed) begin
                        state_nx = NEXT;
                    end else begin
                        state_nx    = FAIL;
                        fail_idx_nx = idx;
                    end
                end else if (wd_hit) begin
                    state_nx    = FAIL;
                    fail_idx_nx = idx;
                    timeout_nx  = 1'b1;
                end
            end
            NEXT: begin
                if (idx == LAST_IDX) begin
                    state_nx = PASS;
                end else begin
                    state_nx = ARM;
                    idx_nx   = idx + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DELAY;
            idx      <= 3'd0;
            fail_idx <= 3'd0;
            timeout  <= 1'b0;
            dly      <= '0;
            wd       <= '0;
            blink    <= '0;
            pulse    <= 4'd0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            fail_idx <= fail_idx_nx;
            timeout  <= timeout_nx;
            dly      <= (state == DELAY) ? dly + 1'b1 : '0;
            if (state_nx == ARM && state != ARM)
                wd <= '0;
            else if ((state == ARM || state == RUN) && !(&wd))
                wd <= wd + 1'b1;
            blink <= (state == FAIL) ? blink + 1'b1 : '0;
            // One frame is fail_idx+1 pulse periods plus a two-period gap.
            if (state != FAIL)
                pulse <= 4'd0;
            else if (&blink)
                pulse <= (pulse == {1'b0, fail_idx} + 4'd2) ? 4'd0 : pulse + 4'd1;
        end
    end

    assign active   = (state == ARM) || (state == RUN);
    assign blink_on = (pulse <= {1'b0, fail_idx}) && !blink[BLINK_BITS-1];

    always_comb begin
        o_run = '0;
        for (int i = 0; i < N_TESTS; i++)
            o_run[i] = active && (idx == 3'(i));
    end

    assign o_done     = (state == PASS) || (state == FAIL);
    assign o_fail_idx = fail_idx;
    assign o_timeout  = timeout;
    assign o_led_g    = (state == PASS);
    assign o_led_r    = (state == FAIL) && blink_on;
    assign o_led_b    = (state == FAIL) ? (timeout && blink_on) : (state != PASS);

endmodule

// File: tb/tb_test_sequencer.sv
// Randomised fixture bench for test_sequencer; outputs are compared each cycle
// against a timeline computed from the sequencing rules.
module tb_test_sequencer;

    localparam int DLY    = 8;
    localparam int TO_LIM = 15;
    localparam int PER    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] drv_run, drv_pas;

    logic [2:0] run_a;
    logic       r_a, g_a, b_a, done_a, to_a;
    logic [2:0] fidx_a;
    logic [0:0] run_b;
    logic       r_b, g_b, b_b, done_b, to_b;
    logic [2:0] fidx_b;

    logic [15:0] obs;
    int          sel;
    int          n_chk;
    int          n_fail;

    int pl_l[8];
    int pl_r[8];
    bit pl_p[8];
    bit pl_pre[8];

    always #5 clk = ~clk;

    test_sequencer #(
        .N_TESTS(3), .DELAY_BITS(3), .TIMEOUT_BITS(4), .BLINK_BITS(2)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_run(run_a), .i_running(drv_run[2:0]), .i_passed(drv_pas[2:0]),
        .o_led_r(r_a), .o_led_g(g_a), .o_led_b(b_a),
        .o_done(done_a), .o_fail_idx(fidx_a), .o_timeout(to_a)
    );

    test_sequencer #(
        .N_TESTS(1), .DELAY_BITS(3), .TIMEOUT_BITS(4), .BLINK_BITS(2)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_run(run_b), .i_running(drv_run[0:0]), .i_passed(drv_pas[0:0]),
        .o_led_r(r_b), .o_led_g(g_b), .o_led_b(b_b),
        .o_done(done_b), .o_fail_idx(fidx_b), .o_timeout(to_b)
    );

    always_comb begin
        if (sel != 0)
            obs = {done_b, fidx_b, to_b, r_b, g_b, b_b, 7'b0, run_b};
        else
            obs = {done_a, fidx_a, to_a, r_a, g_a, b_a, 5'b0, run_a};
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_seq(input int n, input bit abort);
        int arm[8];
        int endc[8];
        int a, fin, fidx, c, k, t, p, lim;
        bit fpass, fto, rr;
        int seen[8];
        logic [7:0]  rv, pv;
        logic [15:0] e;

        for (int i = 0; i < 8; i++) begin
            arm[i]  = 32'h3fff_ffff;
            endc[i] = 32'h3fff_ffff;
            seen[i] = -1;
        end
        a = 2 + DLY;
        fin = 0; fidx = 0; fpass = 0; fto = 0;
        for (int i = 0; i < n; i++) begin
            arm[i] = a;
            if (pl_l[i] + pl_r[i] + 1 > TO_LIM) begin
                endc[i] = a + TO_LIM;
                fin = endc[i]; fidx = i; fto = 1;
                break;
            end
            endc[i] = a + pl_l[i] + pl_r[i] + 1;
            if (!pl_p[i]) begin
                fin = endc[i]; fidx = i;
                break;
            end
            if (i == n - 1) begin
                fin = endc[i] + 1; fpass = 1;
            end else begin
                a = endc[i] + 1;
            end
        end
        lim = fin + (fpass ? 4 : 2 * (fidx + 3) * PER + 2);

        @(posedge clk); #1;
        rst_n   = 1'b0;
        drv_run = 8'($urandom);
        drv_pas = 8'($urandom);
        #1;
        check("reset_outputs", {16'b0, obs}, 32'h0000_0100);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        c = 0;
        while (c < lim) begin
            @(posedge clk); #1;
            c++;
            e = '0;
            for (int i = 0; i < n; i++)
                if (c >= arm[i] && c < endc[i]) e[i] = 1'b1;
            if (c >= fin) begin
                e[15] = 1'b1;
                if (fpass) begin
                    e[9] = 1'b1;
                end else begin
                    t  = c - fin;
                    p  = (t / PER) % (fidx + 3);
                    rr = (p <= fidx) && ((t % PER) < PER / 2);
                    e[14:12] = 3'(fidx);
                    e[11] = fto;
                    e[10] = rr;
                    e[8]  = fto & rr;
                end
            end else begin
                e[8] = 1'b1;
            end
            check($sformatf("cyc%0d", c), {16'b0, obs}, {16'b0, e});

            for (int i = 0; i < 8; i++)
                if (seen[i] < 0 && obs[i]) seen[i] = c;
            for (int i = 0; i < 8; i++) begin
                if (seen[i] < 0) begin
                    rv[i] = pl_pre[i] ? 1'b1 : 1'($urandom_range(0, 1));
                    pv[i] = 1'($urandom_range(0, 1));
                end else begin
                    k = c - seen[i];
                    if (k <= pl_l[i] + pl_r[i])
                        rv[i] = (k >= pl_l[i]) && (k < pl_l[i] + pl_r[i]);
                    else
                        rv[i] = 1'($urandom_range(0, 1));
                    pv[i] = pl_p[i];
                end
            end
            drv_run = rv;
            drv_pas = pv;

            if (abort && seen[2] >= 0 && c - seen[2] == pl_l[2] + 1) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("async_run_drop", {24'b0, obs[7:0]}, 32'h0);
                return;
            end
        end
    endtask

    task automatic set_plan(input int i, input int l, input int r,
                            input bit ps, input bit pre);
        pl_l[i] = l; pl_r[i] = r; pl_p[i] = ps; pl_pre[i] = pre;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; sel = 0;
        rst_n = 1'b0; drv_run = '0; drv_pas = '0;
        for (int i = 0; i < 8; i++) set_plan(i, 0, 1, 1, 0);

        // all pass, 5-cycle fixtures
        for (int i = 0; i < 3; i++) set_plan(i, i % 2, 5, 1, 0);
        run_seq(3, 0);

        // test 1 reports failure
        set_plan(0, 1, 3, 1, 0);
        set_plan(1, 2, 4, 0, 0);
        set_plan(2, 0, 3, 1, 0);
        run_seq(3, 0);

        // test 0 never starts: watchdog in ARM
        set_plan(0, 100, 1, 1, 0);
        run_seq(3, 0);

        // finish on the saturating cycle wins
        set_plan(0, 4, 10, 1, 0);
        set_plan(1, 0, 2, 1, 0);
        set_plan(2, 0, 2, 1, 0);
        run_seq(3, 0);

        // one cycle longer times out in RUN
        set_plan(0, 5, 10, 1, 0);
        run_seq(3, 0);

        // reset during RUN of test 2, then a clean sequence
        set_plan(0, 0, 2, 1, 0);
        set_plan(1, 0, 2, 1, 0);
        set_plan(2, 1, 8, 1, 0);
        run_seq(3, 1);
        for (int i = 0; i < 3; i++) set_plan(i, i, 5, 1, 0);
        run_seq(3, 0);

        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 3; i++)
                set_plan(i, $urandom_range(0, 8), $urandom_range(1, 8),
                         $urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)));
            run_seq(3, 0);
        end

        // single fixture already running before ARM
        sel = 1;
        set_plan(0, 0, 5, 1, 1);
        run_seq(1, 0);
        set_plan(0, 0, 3, 0, 1);
        run_seq(1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
